controller: RTL and testbench

- Debug-command sequencer between the UART debug front end (host side) and the MCU core.
- Accepts one decoded debug function per in_valid pulse.
- Issues the matching one-cycle strobe to the MCU, waits for the MCU to finish, then returns a result word with an out_valid pulse.
- Tracks whether the MCU is paused and gates memory/register-file access on that state.

---
 rtl/controller.sv | 210 +++++++++++++++++++++
 tb/tb_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// controller: debug-command sequencer between the UART debug front end and the MCU core.
// Optional feature macro CTRLR_ADDR_CHECK_EN rejects unaligned READ_MEM/WRITE_MEM requests.
module controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  debug_fn,
  input  logic        in_valid,
  input  logic [31:0] addr,
  input  logic [31:0] d_in,
  input  logic [31:0] pc,
  input  logic        mcu_busy,
  output logic        flush,
  output logic        reset,
  output logic        resume,
  output logic        rf_rd,
  output logic        rf_wr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        out_valid,
  output logic        ctrlr_busy,
  output logic [31:0] d_rd
);

  localparam logic [3:0] FN_PAUSE     = 4'd1;
  localparam logic [3:0] FN_RESUME    = 4'd2;
  localparam logic [3:0] FN_STATUS    = 4'd3;
  localparam logic [3:0] FN_RESET     = 4'd4;
  localparam logic [3:0] FN_READ_MEM  = 4'd5;
  localparam logic [3:0] FN_WRITE_MEM = 4'd6;
  localparam logic [3:0] FN_READ_RF   = 4'd7;
  localparam logic [3:0] FN_WRITE_RF  = 4'd8;
  localparam logic [3:0] FN_READ_PC   = 4'd9;

  localparam logic [31:0] ERR_WORD       = 32'hFFFF_FFFF;
  localparam logic [31:0] ERR_ALIGN_WORD = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_paused;
  logic        r_waitFirst;
  logic        r_outValid;
  logic        r_busy;
  logic [31:0] r_dRd;
  logic [31:0] r_pendResult;
  logic        r_pendRead;
  logic        r_pendPaused;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_unusedAddr;
  logic        w_flush;
  logic        w_reset;
  logic        w_resume;
  logic        w_rfRd;
  logic        w_rfWr;
  logic        w_memRd;
  logic        w_memWr;
  logic        w_anyStrobe;
  logic        w_isRead;
  logic        w_nextPaused;
  logic [31:0] w_result;

  assign w_unusedAddr = ^addr;

`ifdef CTRLR_ADDR_CHECK_EN
  assign w_misaligned = (addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  // Decode of the presented command against the current paused state.
  always_comb begin
    w_flush      = 1'b0;
    w_reset      = 1'b0;
    w_resume     = 1'b0;
    w_rfRd       = 1'b0;
    w_rfWr       = 1'b0;
    w_memRd      = 1'b0;
    w_memWr      = 1'b0;
    w_isRead     = 1'b0;
    w_nextPaused = r_paused;
    w_result     = ERR_WORD;
    case (debug_fn)
      FN_PAUSE: begin
        w_flush      = ~r_paused;
        w_nextPaused = 1'b1;
        w_result     = 32'h0;
      end
      FN_RESUME: begin
        w_resume     = r_paused;
        w_nextPaused = 1'b0;
        w_result     = 32'h0;
      end
      FN_STATUS: w_result = {31'b0, r_paused};
      FN_RESET: begin
        w_reset      = 1'b1;
        w_nextPaused = 1'b0;
        w_result     = 32'h0;
      end
      FN_READ_MEM: begin
        if (w_misaligned) begin
          w_result = ERR_ALIGN_WORD;
        end else if (r_paused) begin
          w_memRd  = 1'b1;
          w_isRead = 1'b1;
          w_result = 32'h0;
        end
      end
      FN_WRITE_MEM: begin
        if (w_misaligned) begin
          w_result = ERR_ALIGN_WORD;
        end else if (r_paused) begin
          w_memWr  = 1'b1;
          w_result = 32'h0;
        end
      end
      FN_READ_RF: begin
        if (r_paused) begin
          w_rfRd   = 1'b1;
          w_isRead = 1'b1;
          w_result = 32'h0;
        end
      end
      FN_WRITE_RF: begin
        if (r_paused) begin
          w_rfWr   = 1'b1;
          w_result = 32'h0;
        end
      end
      FN_READ_PC: w_result = pc;
      default: w_result = ERR_WORD;
    endcase
  end

  assign w_anyStrobe = w_flush | w_reset | w_resume | w_rfRd | w_rfWr | w_memRd | w_memWr;

  // Strobes are Mealy: only the accept cycle in IDLE can raise one.
  assign w_accept = (r_state == S_IDLE) && in_valid && !rst;

  assign flush  = w_accept & w_flush;
  assign reset  = w_accept & w_reset;
  assign resume = w_accept & w_resume;
  assign rf_rd  = w_accept & w_rfRd;
  assign rf_wr  = w_accept & w_rfWr;
  assign mem_rd = w_accept & w_memRd;
  assign mem_wr = w_accept & w_memWr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_paused     <= 1'b0;
      r_waitFirst  <= 1'b0;
      r_outValid   <= 1'b0;
      r_busy       <= 1'b0;
      r_dRd        <= 32'h0;
      r_pendResult <= 32'h0;
      r_pendRead   <= 1'b0;
      r_pendPaused <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_busy <= 1'b1;
            if (w_anyStrobe) begin
              r_state      <= S_WAIT;
              r_waitFirst  <= 1'b1;
              r_pendResult <= w_result;
              r_pendRead   <= w_isRead;
              r_pendPaused <= w_nextPaused;
            end else begin
              r_state    <= S_DONE;
              r_outValid <= 1'b1;
              r_dRd      <= w_result;
              r_paused   <= w_nextPaused;
            end
          end
        end
        // The first WAIT cycle is unconditional so the MCU has time to raise mcu_busy.
        S_WAIT: begin
          r_waitFirst <= 1'b0;
          if (!r_waitFirst && !mcu_busy) begin
            r_state    <= S_DONE;
            r_outValid <= 1'b1;
            r_dRd      <= r_pendRead ? d_in : r_pendResult;
            r_paused   <= r_pendPaused;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = r_outValid;
  assign ctrlr_busy = r_busy;
  assign d_rd       = r_dRd;

endmodule

// File: tb/tb_controller.sv
// tb_controller: table-driven, hand-sequenced and randomized checks of the debug controller.
// Build with +define+CTRLR_ADDR_CHECK_EN to exercise the unaligned-address rejection.
module tb_controller;

  localparam logic [6:0] SB_NONE   = 7'b0000000;
  localparam logic [6:0] SB_FLUSH  = 7'b1000000;
  localparam logic [6:0] SB_RESET  = 7'b0100000;
  localparam logic [6:0] SB_RESUME = 7'b0010000;
  localparam logic [6:0] SB_RFRD   = 7'b0001000;
  localparam logic [6:0] SB_RFWR   = 7'b0000100;
  localparam logic [6:0] SB_MEMRD  = 7'b0000010;
  localparam logic [6:0] SB_MEMWR  = 7'b0000001;

  logic        clock;
  logic        reset;
  logic [3:0]  debugFn;
  logic        inValid;
  logic [31:0] addr;
  logic [31:0] dIn;
  logic [31:0] pcIn;
  logic        mcuBusy;
  logic        flush;
  logic        mcuReset;
  logic        resume;
  logic        rfRd;
  logic        rfWr;
  logic        memRd;
  logic        memWr;
  logic        outValid;
  logic        ctrlrBusy;
  logic [31:0] dRd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  fn;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] din;
    int          busyCycles;
    logic [6:0]  expStrobes;
    logic [31:0] expResult;
    bit          care;
    int          expLat;
  } vec_t;

  vec_t tbl[$];

  logic [6:0]  gStrobes;
  bit          gBusyAcc;
  bit          gBusyDone;
  bit          gExtra;
  int          gLat;
  logic [31:0] gRes;
  bit          gPostValid;
  bit          gPostBusy;
  logic [31:0] gPostRes;

  bit mPaused;

  controller dut (
    .clk       (clock),
    .rst       (reset),
    .debug_fn  (debugFn),
    .in_valid  (inValid),
    .addr      (addr),
    .d_in      (dIn),
    .pc        (pcIn),
    .mcu_busy  (mcuBusy),
    .flush     (flush),
    .reset     (mcuReset),
    .resume    (resume),
    .rf_rd     (rfRd),
    .rf_wr     (rfWr),
    .mem_rd    (memRd),
    .mem_wr    (memWr),
    .out_valid (outValid),
    .ctrlr_busy(ctrlrBusy),
    .d_rd      (dRd)
  );

  // Free-running 100 MHz clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] strobeVec();
    return {flush, mcuReset, resume, rfRd, rfWr, memRd, memWr};
  endfunction

  function automatic vec_t mk(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] p,
                              input logic [31:0] d, input int b, input logic [6:0] s,
                              input logic [31:0] r, input bit c, input int l);
    vec_t v;
    v.fn = fn; v.addr = a; v.pc = p; v.din = d; v.busyCycles = b;
    v.expStrobes = s; v.expResult = r; v.care = c; v.expLat = l;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int step, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL step%0d %s: got=%h want=%h", step, name, got, want);
    end
  endtask

  // Drives one command starting just after a rising edge and plays a simple MCU that
  // holds mcu_busy for b cycles after any strobe it sees.
  task automatic applyStimulus(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] p,
                               input logic [31:0] d, input int b, input bit noise);
    bit strobed;
    debugFn = fn; addr = a; pcIn = p; dIn = d; inValid = 1'b1; mcuBusy = 1'b0;
    #1;
    gStrobes  = strobeVec();
    gBusyAcc  = ctrlrBusy;
    strobed   = (gStrobes != SB_NONE);
    gExtra    = 1'b0;
    gLat      = -1;
    gRes      = 32'h0;
    gBusyDone = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      inValid = noise;
      if (noise) debugFn = 4'd3;
      mcuBusy = strobed && (k <= b);
      #1;
      if (strobeVec() != SB_NONE) gExtra = 1'b1;
      if (outValid) begin
        gLat      = k;
        gRes      = dRd;
        gBusyDone = ctrlrBusy;
        inValid   = 1'b0;
        break;
      end
    end
    mcuBusy = 1'b0;
    inValid = 1'b0;
    dIn     = ~d;
    @(posedge clock); #2;
    gPostValid = outValid;
    gPostBusy  = ctrlrBusy;
    gPostRes   = dRd;
  endtask

  task automatic checkCmd(input int step, input logic [6:0] s, input logic [31:0] r,
                          input bit c, input int l);
    checkOutput("strobes", step, 32'(gStrobes), 32'(s));
    checkOutput("busyAtAccept", step, 32'(gBusyAcc), 32'd0);
    checkOutput("latency", step, gLat, l);
    checkOutput("noLateStrobe", step, 32'(gExtra), 32'd0);
    checkOutput("busyAtDone", step, 32'(gBusyDone), 32'd1);
    checkOutput("idleAfterDone", step, {30'b0, gPostValid, gPostBusy}, 32'd0);
    if (c) begin
      checkOutput("result", step, gRes, r);
      checkOutput("resultHeld", step, gPostRes, r);
    end
  endtask

  // Reference: what a command should do given the host-visible paused flag.
  task automatic model(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] p,
                       input logic [31:0] d, input int b, output logic [6:0] s,
                       output logic [31:0] r, output bit c, output int l);
    bit unaligned;
    s = SB_NONE; r = 32'hFFFF_FFFF; c = 1'b1;
`ifdef CTRLR_ADDR_CHECK_EN
    unaligned = (fn == 4'd5 || fn == 4'd6) && (a[1:0] != 2'b00);
`else
    unaligned = (a == 32'h1) && 1'b0;
`endif
    case (fn)
      4'd1: begin
        if (!mPaused) begin s = SB_FLUSH; c = 1'b0; end
        else r = 32'h0;
        mPaused = 1'b1;
      end
      4'd2: begin
        c = 1'b0;
        if (mPaused) s = SB_RESUME;
        mPaused = 1'b0;
      end
      4'd3: r = {31'b0, mPaused};
      4'd4: begin s = SB_RESET; r = 32'h0; mPaused = 1'b0; end
      4'd5, 4'd6, 4'd7, 4'd8: begin
        if (unaligned) r = 32'hFFFF_FFFE;
        else if (mPaused) begin
          case (fn)
            4'd5:    begin s = SB_MEMRD; r = d; end
            4'd6:    begin s = SB_MEMWR; r = 32'h0; end
            4'd7:    begin s = SB_RFRD;  r = d; end
            default: begin s = SB_RFWR;  r = 32'h0; end
          endcase
        end
      end
      4'd9: r = p;
      default: ;
    endcase
    l = (s != SB_NONE) ? ((b + 2 > 3) ? b + 2 : 3) : 1;
  endtask

  initial begin
    int idle;
    int extraValid;
    logic [3:0]  rFn;
    logic [31:0] rAddr, rPc, rDin;
    int          rB, rSel;
    logic [6:0]  eS;
    logic [31:0] eR;
    bit          eC;
    int          eL;

    reset = 1'b1; debugFn = 4'd0; inValid = 1'b0; addr = 32'h0;
    dIn = 32'h0; pcIn = 32'h0; mcuBusy = 1'b0;
    #3;
    checkOutput("resetStrobes", 0, 32'(strobeVec()), 32'd0);
    checkOutput("resetValidBusy", 0, {30'b0, outValid, ctrlrBusy}, 32'd0);
    checkOutput("resetData", 0, dRd, 32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    tbl.push_back(mk(4'd1, 32'h0, 32'h0, 32'h0, 6,  SB_FLUSH,  32'h0, 1'b0, 8));
    tbl.push_back(mk(4'd3, 32'h0, 32'h0, 32'h0, 0,  SB_NONE,   32'h1, 1'b1, 1));
    tbl.push_back(mk(4'd5, 32'h0, 32'h0, 32'h28, 13, SB_MEMRD, 32'h28, 1'b1, 15));
    tbl.push_back(mk(4'd1, 32'h0, 32'h0, 32'h0, 0,  SB_NONE,   32'h0, 1'b1, 1));
    tbl.push_back(mk(4'd8, 32'h0, 32'h0, 32'h0, 2,  SB_RFWR,   32'h0, 1'b1, 4));
    tbl.push_back(mk(4'd7, 32'h0, 32'h0, 32'h1234, 0, SB_RFRD, 32'h1234, 1'b1, 3));
`ifdef CTRLR_ADDR_CHECK_EN
    tbl.push_back(mk(4'd6, 32'h6, 32'h0, 32'h0, 1,  SB_NONE,   32'hFFFF_FFFE, 1'b1, 1));
`else
    tbl.push_back(mk(4'd6, 32'h6, 32'h0, 32'h0, 1,  SB_MEMWR,  32'h0, 1'b1, 3));
`endif
    tbl.push_back(mk(4'd2, 32'h0, 32'h0, 32'h0, 0,  SB_RESUME, 32'h0, 1'b0, 3));
    tbl.push_back(mk(4'd3, 32'h0, 32'h0, 32'h0, 0,  SB_NONE,   32'h0, 1'b1, 1));
    tbl.push_back(mk(4'd2, 32'h0, 32'h0, 32'h0, 0,  SB_NONE,   32'h0, 1'b0, 1));
    tbl.push_back(mk(4'd7, 32'h0, 32'h0, 32'h55, 0, SB_NONE,   32'hFFFF_FFFF, 1'b1, 1));
    tbl.push_back(mk(4'd9, 32'h0, 32'h40, 32'h0, 0, SB_NONE,   32'h40, 1'b1, 1));
    tbl.push_back(mk(4'd6, 32'h0, 32'h0, 32'h0, 0,  SB_NONE,   32'hFFFF_FFFF, 1'b1, 1));
    tbl.push_back(mk(4'd0, 32'h0, 32'h0, 32'h0, 0,  SB_NONE,   32'hFFFF_FFFF, 1'b1, 1));
    tbl.push_back(mk(4'd12, 32'h0, 32'h0, 32'h0, 0, SB_NONE,   32'hFFFF_FFFF, 1'b1, 1));
    tbl.push_back(mk(4'd4, 32'h0, 32'h0, 32'h0, 3,  SB_RESET,  32'h0, 1'b1, 5));
    tbl.push_back(mk(4'd1, 32'h0, 32'h0, 32'h0, 0,  SB_FLUSH,  32'h0, 1'b0, 3));
    tbl.push_back(mk(4'd4, 32'h0, 32'h0, 32'h0, 0,  SB_RESET,  32'h0, 1'b1, 3));
    tbl.push_back(mk(4'd3, 32'h0, 32'h0, 32'h0, 0,  SB_NONE,   32'h0, 1'b1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].fn, tbl[i].addr, tbl[i].pc, tbl[i].din, tbl[i].busyCycles, 1'b0);
      checkCmd(i + 1, tbl[i].expStrobes, tbl[i].expResult, tbl[i].care, tbl[i].expLat);
    end

    // in_valid held high during WAIT/DONE must not start a second command.
    applyStimulus(4'd4, 32'h0, 32'h0, 32'h0, 4, 1'b1);
    checkCmd(100, SB_RESET, 32'h0, 1'b1, 6);
    extraValid = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      if (outValid) extraValid++;
    end
    checkOutput("noSecondValid", 100, extraValid, 0);

    // Reset while waiting on the MCU aborts the command and clears paused.
    applyStimulus(4'd1, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    checkCmd(101, SB_FLUSH, 32'h0, 1'b0, 3);
    applyStimulus(4'd9, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    checkCmd(102, SB_NONE, 32'hDEAD_BEEF, 1'b1, 1);
    debugFn = 4'd5; addr = 32'h0; dIn = 32'h77; inValid = 1'b1;
    #1;
    checkOutput("midResetAccept", 103, 32'(strobeVec()), 32'(SB_MEMRD));
    @(posedge clock); #1;
    inValid = 1'b0; mcuBusy = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checkOutput("midResetBusy", 103, {30'b0, outValid, ctrlrBusy}, 32'd0);
    checkOutput("midResetData", 103, dRd, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0; mcuBusy = 1'b0;
    extraValid = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (outValid) extraValid++;
    end
    checkOutput("abortedNoValid", 103, extraValid, 0);
    applyStimulus(4'd3, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    checkCmd(104, SB_NONE, 32'h0, 1'b1, 1);

    // Randomized commands against the reference model.
    mPaused = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rSel  = $urandom_range(0, 19);
      rFn   = (rSel < 16) ? 4'(rSel) : ((rSel < 18) ? 4'd1 : 4'd5);
      rAddr = {$urandom_range(0, 255), 2'(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0)};
      rPc   = $urandom;
      rDin  = $urandom;
      rB    = $urandom_range(0, 5);
      model(rFn, rAddr, rPc, rDin, rB, eS, eR, eC, eL);
      applyStimulus(rFn, rAddr, rPc, rDin, rB, 1'b0);
      checkCmd(200 + i, eS, eR, eC, eL);
    end

    idle = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
